// File: rtl/qam16_symbol_mixer.sv
// qam16_symbol_mixer: buffers 16-QAM symbols and mixes the selected I/Q carrier samples into one saturated DAC sample
module qam16_symbol_mixer #(
  parameter int DW     = 8,
  parameter int OFFSET = 100,
  parameter int FIFO_D = 4,
  parameter int PERIOD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    sym_data,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic [DW-1:0] i_w0,
  input  logic [DW-1:0] i_w1,
  input  logic [DW-1:0] i_w2,
  input  logic [DW-1:0] i_w3,
  input  logic [DW-1:0] q_w0,
  input  logic [DW-1:0] q_w1,
  input  logic [DW-1:0] q_w2,
  input  logic [DW-1:0] q_w3,
  output logic [DW-1:0] mod_out,
  output logic          out_valid,
  output logic          sym_start,
  output logic          underflow
);
  localparam int PW = $clog2(PERIOD);
  localparam int AW = $clog2(FIFO_D);
  localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_D);
  localparam logic signed [DW+1:0] OFF = (DW + 2)'(OFFSET);
  localparam logic [DW-1:0] IDLE_LVL = DW'(OFFSET);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [PW-1:0] phase;
  logic [3:0] mem [FIFO_D];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [3:0] cur_sym;
  logic alive, active, boundary, empty, push, pop;
  logic [DW-1:0] i_mux, q_mux, i_sel, q_sel, sat;
  logic act1, ph0_1, v1;
  logic signed [DW+1:0] s;
  assign boundary = phase == LAST;
  assign empty = count == '0;
  assign sym_ready = alive & (count != FULL);
  assign push = sym_valid & sym_ready;
  assign pop = boundary & ~empty;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb state_nx = boundary ? (empty ? IDLE : RUN) : state;
  always_comb active = state == RUN;
  always_ff @(posedge clk)
    if (push) mem[wp] <= sym_data;
  // Pop uses the registered count, so a symbol written on a boundary edge waits a full period
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      cur_sym <= '0;
      alive <= 1'b0;
      underflow <= 1'b0;
    end else begin
      phase <= phase + 1'b1;
      alive <= 1'b1;
      underflow <= boundary & empty;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        cur_sym <= mem[rp];
        rp <= rp + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign i_mux = cur_sym[3] ? (cur_sym[2] ? i_w3 : i_w2) : (cur_sym[2] ? i_w1 : i_w0);
  assign q_mux = cur_sym[1] ? (cur_sym[0] ? q_w3 : q_w2) : (cur_sym[0] ? q_w1 : q_w0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_sel <= '0;
      q_sel <= '0;
      act1 <= 1'b0;
      ph0_1 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      i_sel <= i_mux;
      q_sel <= q_mux;
      act1 <= active;
      ph0_1 <= phase == '0;
      v1 <= 1'b1;
    end
  end
  assign s = $signed({2'b00, i_sel}) + $signed({2'b00, q_sel}) - OFF;
  assign sat = s[DW+1] ? '0 : (s[DW] ? '1 : s[DW-1:0]);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mod_out <= IDLE_LVL;
      out_valid <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      mod_out <= act1 ? sat : IDLE_LVL;
      out_valid <= v1;
      sym_start <= ph0_1 & act1;
    end
  end
endmodule

// File: tb/tb_qam16_symbol_mixer.sv
// tb_qam16_symbol_mixer: directed stimulus checked every cycle against a queue-based symbol/sample model
module tb_qam16_symbol_mixer;
  logic clk = 1'b0, rst_n = 1'b0, sym_valid = 1'b0;
  logic [3:0] sym_data = '0;
  logic [7:0] iw [4];
  logic [7:0] qw [4];
  logic [7:0] mod_out, mod2;
  logic out_valid, sym_start, underflow, sym_ready, ov2, ss2, uf2, rdy2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  qam16_symbol_mixer dut (
    .clk(clk), .rst_n(rst_n), .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .i_w0(iw[0]), .i_w1(iw[1]), .i_w2(iw[2]), .i_w3(iw[3]),
    .q_w0(qw[0]), .q_w1(qw[1]), .q_w2(qw[2]), .q_w3(qw[3]),
    .mod_out(mod_out), .out_valid(out_valid), .sym_start(sym_start), .underflow(underflow)
  );
  qam16_symbol_mixer #(.OFFSET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(rdy2),
    .i_w0(iw[0]), .i_w1(iw[1]), .i_w2(iw[2]), .i_w3(iw[3]),
    .q_w0(qw[0]), .q_w1(qw[1]), .q_w2(qw[2]), .q_w3(qw[3]),
    .mod_out(mod2), .out_valid(ov2), .sym_start(ss2), .underflow(uf2)
  );
  typedef struct {int a; int b; bit ss;} ent_t;
  ent_t prev, cur_e;
  bit have_prev, m_act, m_rdy, m_uf, e_ov, e_ss, started = 1'b0;
  int m_ph, e_mod, e_mod2, iv, qv;
  logic [3:0] m_cur;
  logic [3:0] m_q[$];
  function automatic int clampv(int v);
    return v < 0 ? 0 : (v > 255 ? 255 : v);
  endfunction
  // Each edge records the sample the current symbol calls for; it appears on mod_out one edge later
  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      have_prev = 0; m_ph = 0; m_act = 0; m_rdy = 0; m_uf = 0; m_cur = '0;
      e_mod = 100; e_mod2 = 0; e_ov = 0; e_ss = 0;
    end else begin
      iv = iw[m_cur[3:2]];
      qv = qw[m_cur[1:0]];
      cur_e.a = m_act ? clampv(iv + qv - 100) : 100;
      cur_e.b = m_act ? clampv(iv + qv) : 0;
      cur_e.ss = m_act && m_ph == 0;
      e_mod = have_prev ? prev.a : 100;
      e_mod2 = have_prev ? prev.b : 0;
      e_ss = have_prev && prev.ss;
      e_ov = have_prev;
      prev = cur_e;
      have_prev = 1;
      m_uf = m_ph == 15 && m_q.size() == 0;
      if (m_ph == 15) begin
        m_act = m_q.size() > 0;
        if (m_act) m_cur = m_q.pop_front();
      end
      if (sym_valid && m_rdy) m_q.push_back(sym_data);
      m_ph = (m_ph + 1) % 16;
      m_rdy = m_q.size() < 4;
    end
  end
  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk)
    if (started) begin
      chk("mod_out", mod_out, e_mod);
      chk("mod_out_off0", mod2, e_mod2);
      chk("out_valid", out_valid, e_ov);
      chk("sym_start", sym_start, e_ss);
      chk("underflow", underflow, m_uf);
      chk("sym_ready", sym_ready, m_rdy);
    end
  int n100, n242, n0, n255a, n255b, nss, nuf, nov, nacc;
  logic [3:0] seq [8] = '{4'h5, 4'hA, 4'h3, 4'hC, 4'h6, 4'h9, 4'hF, 4'h0};
  task automatic clr();
    n100 = 0; n242 = 0; n0 = 0; n255a = 0; n255b = 0; nss = 0; nuf = 0; nov = 0;
  endtask
  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n100 += int'(mod_out == 8'd100);
      n242 += int'(mod_out == 8'd242);
      n0 += int'(mod_out == 8'd0);
      n255a += int'(mod_out == 8'd255);
      n255b += int'(mod2 == 8'd255);
      nss += int'(sym_start);
      nuf += int'(underflow);
      nov += int'(out_valid);
    end
  endtask
  task automatic push(logic [3:0] d);
    sym_data = d;
    sym_valid = 1'b1;
    tick(1);
    sym_valid = 1'b0;
  endtask
  task automatic wait_ph(int p);
    for (int i = 0; i < 32 && m_ph != p; i++) tick(1);
    chk("phase_align", m_ph, p);
  endtask
  initial begin
    for (int k = 0; k < 4; k++) begin
      iw[k] = '0;
      qw[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 started = 1'b1;
    @(negedge clk);
    chk("rst_mod_out", mod_out, 100);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ready", sym_ready, 0);
    rst_n = 1'b1;
    clr();
    tick(20);
    chk("t1_idle_level", n100, 20);
    chk("t1_valid_cycles", nov, 19);
    chk("t1_underflows", nuf, 1);
    iw[3] = 8'd171; qw[3] = 8'd171;
    push(4'hF);
    clr();
    tick(40);
    chk("t2_242_samples", n242, 16);
    chk("t2_sym_starts", nss, 1);
    iw[0] = 8'd29; qw[0] = 8'd29;
    push(4'h0);
    clr();
    tick(40);
    chk("t3_low_clamp", n0, 16);
    iw[1] = 8'd200; qw[1] = 8'd200;
    push(4'h5);
    clr();
    tick(40);
    chk("t3_high_clamp", n255a, 16);
    chk("t3_high_clamp_off0", n255b, 16);
    iw = '{8'd40, 8'd60, 8'd80, 8'd120};
    qw = '{8'd10, 8'd30, 8'd50, 8'd70};
    wait_ph(1);
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      sym_data = seq[k];
      sym_valid = 1'b1;
      nacc += int'(sym_ready);
      tick(1);
    end
    sym_valid = 1'b0;
    chk("t4_accepted", nacc, 4);
    chk("t4_ready_full", sym_ready, 0);
    clr();
    tick(80);
    chk("t4_sym_starts", nss, 4);
    wait_ph(15);
    push(4'h6);
    chk("t5_underflow", underflow, 1);
    clr();
    tick(40);
    chk("t5_sym_starts", nss, 1);
    push(4'h9);
    push(4'h3);
    tick(20);
    rst_n = 1'b0;
    tick(1);
    chk("t6_mod_out", mod_out, 100);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_ready", sym_ready, 0);
    rst_n = 1'b1;
    clr();
    tick(60);
    chk("t6_no_stale", nss, 0);
    chk("t6_idle", n100, 60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
